// File: rtl/spi_pkg.sv
// Shared SPI definitions: bit-order constants, mode bundle and the slave's frame-tracking states.
package spi_pkg;

  localparam logic SPI_MSB_FIRST = 1'b1;
  localparam logic SPI_LSB_FIRST = 1'b0;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic dir;
  } spi_mode_t;

  // SETTLE lets the pin synchronizers flush after reset so a held-low ss is not taken as a fresh frame.
  typedef enum logic [1:0] {
    FRM_SETTLE = 2'd0,
    FRM_IDLE   = 2'd1,
    FRM_ACTIVE = 2'd2
  } frame_state_t;

  localparam logic [1:0] SETTLE_CYCLES = 2'd3;

endpackage

// File: rtl/spi_slave_unit_if.sv
// Pin and handshake bundle of the SPI target; the slave modport is the DUT view, master the driver view.
interface spi_slave_unit_if #(
  parameter int DATAWIDTH = 8
);

  logic                 clockPolarity;
  logic                 clockPhase;
  logic                 dataDirection;
  logic                 transmitValid;
  logic [DATAWIDTH-1:0] dataRegIn;
  logic                 transmitReady;
  logic [DATAWIDTH-1:0] dataReg;
  logic                 receiveValid;
  logic                 txUnderrun;
  logic                 frameError;
  logic                 sclk;
  logic                 ss;
  logic                 mosi;
  logic                 miso;
  logic                 misoEnable;

  modport slave (
    input  clockPolarity, clockPhase, dataDirection, transmitValid, dataRegIn,
    input  sclk, ss, mosi,
    output transmitReady, dataReg, receiveValid, txUnderrun, frameError,
    output miso, misoEnable
  );

  modport master (
    output clockPolarity, clockPhase, dataDirection, transmitValid, dataRegIn,
    output sclk, ss, mosi,
    input  transmitReady, dataReg, receiveValid, txUnderrun, frameError,
    input  miso, misoEnable
  );

endinterface

// File: rtl/spi_slave_unit_sync_edge.sv
// Two-flop pin synchronizer with a history flop; rise/fall flag the cycle the synchronized level changes.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  input  logic rst_val_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus previous-value register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
      prev_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_unit.sv
// SPI target endpoint: oversampled sclk/ss/mosi, one-entry transmit holding register, all CPOL/CPHA modes.
module spi_slave_unit
  import spi_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  spi_slave_unit_if.slave bus
);

  localparam int             CW       = $clog2(DATAWIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATAWIDTH - 1);

  spi_mode_t mode_s;
  logic      msb_first_s;

  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic ss_level_s, ss_rise_s, ss_fall_s;
  logic mosi_meta_q, mosi_sync_q;

  logic sclk_moved_s, lead_s, trail_s;
  logic active_s, frame_start_s, frame_end_s;
  logic sample_s, shift_s, load_s, handshake_s;

  frame_state_t   state_q, state_d;
  logic [1:0]     settle_q, settle_d;

  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATAWIDTH-1:0] rx_q, rx_d;
  logic [DATAWIDTH-1:0] tx_q, tx_d;
  logic [DATAWIDTH-1:0] hold_q, hold_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic tx_ready_q, tx_ready_d;
  logic rv_q, rv_d;
  logic ur_q, ur_d;
  logic fe_q, fe_d;
  logic miso_q, miso_d;
  logic miso_en_q, miso_en_d;

  assign mode_s      = '{cpol: bus.clockPolarity, cpha: bus.clockPhase, dir: bus.dataDirection};
  assign msb_first_s = (mode_s.dir == SPI_MSB_FIRST);

  spi_sync_edge u_sclk_sync (
    .clk       (clk),
    .reset     (reset),
    .d_i       (bus.sclk),
    .rst_val_i (bus.clockPolarity),
    .level_o   (sclk_level_s),
    .rise_o    (sclk_rise_s),
    .fall_o    (sclk_fall_s)
  );

  spi_sync_edge u_ss_sync (
    .clk       (clk),
    .reset     (reset),
    .d_i       (bus.ss),
    .rst_val_i (1'b1),
    .level_o   (ss_level_s),
    .rise_o    (ss_rise_s),
    .fall_o    (ss_fall_s)
  );

  // mosi synchronizer, same depth as sclk so samples line up with detected edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= bus.mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_moved_s  = sclk_rise_s | sclk_fall_s;
  assign lead_s        = sclk_moved_s & (sclk_level_s != mode_s.cpol);
  assign trail_s       = sclk_moved_s & (sclk_level_s == mode_s.cpol);
  assign active_s      = (state_q == FRM_ACTIVE) & ~ss_level_s;
  assign frame_start_s = (state_q == FRM_IDLE) & ss_fall_s;
  assign frame_end_s   = (state_q == FRM_ACTIVE) & ss_rise_s;
  assign sample_s      = active_s & (mode_s.cpha ? trail_s : lead_s);
  assign shift_s       = active_s & (mode_s.cpha ? lead_s : trail_s);
  // A shift edge with the counter at zero starts a new word; CPHA=0 also loads at the ss fall.
  assign load_s        = (frame_start_s & ~mode_s.cpha) | (shift_s & (bit_cnt_q == '0));
  assign handshake_s   = bus.transmitValid & tx_ready_q;

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FRM_SETTLE;
      settle_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Frame next-state logic
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      FRM_SETTLE: begin
        if (settle_q != SETTLE_CYCLES) begin
          settle_d = settle_q + 2'd1;
        end else if (ss_level_s) begin
          state_d = FRM_IDLE;
        end else begin
          state_d = FRM_SETTLE;
        end
      end
      FRM_IDLE: begin
        if (ss_fall_s) begin
          state_d = FRM_ACTIVE;
        end else begin
          state_d = FRM_IDLE;
        end
      end
      FRM_ACTIVE: begin
        if (ss_rise_s) begin
          state_d = FRM_IDLE;
        end else begin
          state_d = FRM_ACTIVE;
        end
      end
      default: begin
        state_d = FRM_SETTLE;
      end
    endcase
  end

  // Datapath next-state: holding register, shift registers, counter and pulses
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    data_d     = data_q;
    tx_ready_d = tx_ready_q;
    rv_d       = 1'b0;
    ur_d       = 1'b0;
    fe_d       = 1'b0;
    miso_en_d  = ~ss_level_s;

    // Load sees the holding contents from before any same-cycle handshake
    if (load_s) begin
      if (tx_ready_q) begin
        tx_d = '1;
        ur_d = 1'b1;
      end else begin
        tx_d = hold_q;
        ur_d = 1'b0;
      end
      tx_ready_d = 1'b1;
    end else if (shift_s) begin
      if (msb_first_s) begin
        tx_d = {tx_q[DATAWIDTH-2:0], 1'b0};
      end else begin
        tx_d = {1'b0, tx_q[DATAWIDTH-1:1]};
      end
    end else begin
      tx_d = tx_q;
    end

    if (handshake_s) begin
      hold_d     = bus.dataRegIn;
      tx_ready_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end

    miso_d = msb_first_s ? tx_d[DATAWIDTH-1] : tx_d[0];

    if (frame_end_s) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      fe_d      = (bit_cnt_q != '0);
    end else if (sample_s) begin
      if (msb_first_s) begin
        rx_d = {rx_q[DATAWIDTH-2:0], mosi_sync_q};
      end else begin
        rx_d = {mosi_sync_q, rx_q[DATAWIDTH-1:1]};
      end
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        data_d    = rx_d;
        rv_d      = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else begin
      rx_d = rx_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      tx_ready_q <= 1'b1;
      rv_q       <= 1'b0;
      ur_q       <= 1'b0;
      fe_q       <= 1'b0;
      miso_q     <= 1'b0;
      miso_en_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      tx_ready_q <= tx_ready_d;
      rv_q       <= rv_d;
      ur_q       <= ur_d;
      fe_q       <= fe_d;
      miso_q     <= miso_d;
      miso_en_q  <= miso_en_d;
    end
  end

  assign bus.transmitReady = tx_ready_q;
  assign bus.dataReg       = data_q;
  assign bus.receiveValid  = rv_q;
  assign bus.txUnderrun    = ur_q;
  assign bus.frameError    = fe_q;
  assign bus.miso          = miso_q;
  assign bus.misoEnable    = miso_en_q;

endmodule

// File: tb/tb_spi_slave_unit.sv
// Directed and randomized bench for spi_slave_unit; the bench acts as SPI master and checks against expected words.
module tb_spi_slave_unit;

  localparam int W    = 12;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_unit_if #(.DATAWIDTH(W)) bus ();
  spi_slave_unit #(.DATAWIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests_run    = 0;
  int tests_failed = 0;
  int rv_cnt = 0;
  int ur_cnt = 0;
  int fe_cnt = 0;
  logic [2:0] mode_r;  // {cpol, cpha, msb_first}

  always @(negedge clk) begin
    if (bus.receiveValid) rv_cnt <= rv_cnt + 1;
    if (bus.txUnderrun)   ur_cnt <= ur_cnt + 1;
    if (bus.frameError)   fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position in the serial stream of the i-th bit on the wire, word 0 in the low W bits
  function automatic int bit_index(input int i);
    int b;
    b = i % W;
    return (i / W) * W + (mode_r[0] ? (W - 1 - b) : b);
  endfunction

  task automatic set_mode(input logic [2:0] m);
    mode_r            = m;
    bus.clockPolarity = m[2];
    bus.clockPhase    = m[1];
    bus.dataDirection = m[0];
    bus.sclk          = m[2];
    repeat (6) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.transmitReady && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_wait", 32'(bus.transmitReady), 32'd1);
    bus.transmitValid = 1'b1;
    bus.dataRegIn     = w;
    @(negedge clk);
    bus.transmitValid = 1'b0;
    check("push_ready_drops", 32'(bus.transmitReady), 32'd0);
  endtask

  task automatic master_xfer(input logic [2*W-1:0] tx, input int nbits, input bit leave_low,
                             output logic [2*W-1:0] rx);
    rx     = '0;
    bus.ss = 1'b0;
    if (!mode_r[1]) bus.mosi = tx[bit_index(0)];
    repeat (HALF) @(negedge clk);
    check("miso_enable", 32'(bus.misoEnable), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (mode_r[1]) begin
        bus.sclk = ~mode_r[2];
        bus.mosi = tx[bit_index(i)];
        repeat (HALF) @(negedge clk);
        bus.sclk = mode_r[2];
        rx[bit_index(i)] = bus.miso;
        repeat (HALF) @(negedge clk);
      end else begin
        bus.sclk = ~mode_r[2];
        rx[bit_index(i)] = bus.miso;
        repeat (HALF) @(negedge clk);
        bus.sclk = mode_r[2];
        if (i + 1 < 2 * W) bus.mosi = tx[bit_index(i + 1)];
        repeat (HALF) @(negedge clk);
      end
    end
    if (!leave_low) begin
      bus.ss = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dataReg"},       32'(bus.dataReg),       32'd0);
    check({tag, "_receiveValid"},  32'(bus.receiveValid),  32'd0);
    check({tag, "_txUnderrun"},    32'(bus.txUnderrun),    32'd0);
    check({tag, "_frameError"},    32'(bus.frameError),    32'd0);
    check({tag, "_miso"},          32'(bus.miso),          32'd0);
    check({tag, "_misoEnable"},    32'(bus.misoEnable),    32'd0);
    check({tag, "_transmitReady"}, 32'(bus.transmitReady), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] cap;
    logic [W-1:0]   exp_data;
    int r0, u0, f0;

    reset             = 1'b0;
    mode_r            = 3'b000;
    bus.clockPolarity = 1'b0;
    bus.clockPhase    = 1'b0;
    bus.dataDirection = 1'b0;
    bus.transmitValid = 1'b0;
    bus.dataRegIn     = '0;
    bus.sclk          = 1'b0;
    bus.ss            = 1'b1;
    bus.mosi          = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 3, MSB first
    set_mode(3'b111);
    push(12'h5A3);
    r0 = rv_cnt; u0 = ur_cnt;
    master_xfer({12'h000, 12'hAAA}, W, 1'b0, cap);
    check("m3_rv_pulses", 32'(rv_cnt - r0), 32'd1);
    check("m3_dataReg",   32'(bus.dataReg), 32'h0AAA);
    check("m3_captured",  32'(cap[W-1:0]), 32'h05A3);
    check("m3_underrun",  32'(ur_cnt - u0), 32'd0);

    // Mode 0, LSB first
    set_mode(3'b000);
    push(12'h0F1);
    r0 = rv_cnt;
    master_xfer({12'h000, 12'h123}, W, 1'b0, cap);
    check("m0_rv_pulses", 32'(rv_cnt - r0), 32'd1);
    check("m0_dataReg",   32'(bus.dataReg), 32'h0123);
    check("m0_captured",  32'(cap[W-1:0]), 32'h00F1);

    // Underrun: nothing queued before the frame
    set_mode(3'b111);
    u0 = ur_cnt;
    master_xfer({12'h000, 12'h6C9}, W, 1'b0, cap);
    check("ur_pulses",   32'(ur_cnt - u0), 32'd1);
    check("ur_captured", 32'(cap[W-1:0]), 32'h0FFF);
    check("ur_dataReg",  32'(bus.dataReg), 32'h06C9);

    // Back-to-back, mode 1, second word queued once the first is taken
    set_mode(3'b011);
    push(12'h111);
    r0 = rv_cnt; u0 = ur_cnt;
    fork
      master_xfer({12'h9A6, 12'h3C5}, 2 * W, 1'b0, cap);
      push(12'h222);
    join
    check("b2b_rv_pulses", 32'(rv_cnt - r0), 32'd2);
    check("b2b_cap0",      32'(cap[W-1:0]), 32'h0111);
    check("b2b_cap1",      32'(cap[2*W-1:W]), 32'h0222);
    check("b2b_dataReg",   32'(bus.dataReg), 32'h09A6);
    check("b2b_underrun",  32'(ur_cnt - u0), 32'd0);
    exp_data = 12'h9A6;

    // Abort after 5 bits
    set_mode(3'b001);
    push(12'h777);
    r0 = rv_cnt; f0 = fe_cnt;
    master_xfer({12'h000, 12'h5E1}, 5, 1'b0, cap);
    check("abort_frameError", 32'(fe_cnt - f0), 32'd1);
    check("abort_no_rv",      32'(rv_cnt - r0), 32'd0);
    check("abort_dataReg",    32'(bus.dataReg), 32'(exp_data));
    push(12'h4B2);
    f0 = fe_cnt;
    master_xfer({12'h000, 12'hC3D}, W, 1'b0, cap);
    check("after_abort_dataReg",  32'(bus.dataReg), 32'h0C3D);
    check("after_abort_captured", 32'(cap[W-1:0]), 32'h04B2);
    check("after_abort_no_fe",    32'(fe_cnt - f0), 32'd0);

    // Reset at bit 6 of a frame
    set_mode(3'b101);
    push(12'h3E7);
    f0 = fe_cnt;
    master_xfer({12'h000, 12'h2D4}, 6, 1'b1, cap);
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    bus.ss = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_fe", 32'(fe_cnt - f0), 32'd0);
    push(12'h1F8);
    master_xfer({12'h000, 12'hE06}, W, 1'b0, cap);
    check("post_reset_dataReg",  32'(bus.dataReg), 32'h0E06);
    check("post_reset_captured", 32'(cap[W-1:0]), 32'h01F8);

    // Random modes and words; CPHA=0 also loads on the frame's final trailing edge
    for (int k = 0; k < 6; k++) begin
      logic [2:0]   m;
      logic [W-1:0] hw, rw, exp_cap;
      int           have, exp_ur;
      m    = 3'($urandom_range(0, 7));
      have = int'($urandom_range(0, 1));
      hw   = W'($urandom);
      rw   = W'($urandom);
      set_mode(m);
      if (have != 0) push(hw);
      r0 = rv_cnt; u0 = ur_cnt;
      master_xfer({12'h000, rw}, W, 1'b0, cap);
      exp_cap = (have != 0) ? hw : {W{1'b1}};
      exp_ur  = (m[1] ? 1 : 2) - have;
      check("rnd_dataReg",  32'(bus.dataReg), 32'(rw));
      check("rnd_captured", 32'(cap[W-1:0]), 32'(exp_cap));
      check("rnd_rv",       32'(rv_cnt - r0), 32'd1);
      check("rnd_underrun", 32'(ur_cnt - u0), 32'(exp_ur));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
